changecode_sched: RTL and testbench
===================================

Name: changecode_sched

Overview:
- Round-robin scheduler that shares one `changecode` conversion unit (two's complement -> sign-magnitude, BITS wide) between NREQ requesters inside the APB execution unit.
- Each request is granted, its operand captured, converted, and the registered result returned with the requester ID over a valid/ready handshake.
- Only one conversion is in flight at a time.

Parameters:
- BITS, 4, operand/result width in bits.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), requester ID width; localparam, not overridable.

Ports:
- i_clk  input  1  clock, rising-edge active.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_req  input  NREQ  request per requester; level, held until granted.
- i_argA  input  NREQ*BITS  packed operands; slice k is requester k's signed operand.
- o_gnt  output  NREQ  one-hot grant, one-cycle pulse.
- o_valid  output  1  result available.
- i_ready  input  1  consumer accepts result.
- o_result  output  BITS  converted result.
- o_error  output  1  operand was the most negative value.
- o_id  output  IDW  index of the requester that owns the result.
- o_busy  output  1  high when FSM is not in S_IDLE.

Behaviour:
- Reset values: all outputs 0. State = S_IDLE. Round-robin pointer = NREQ-1, so requester 0 has first priority. Operand register = 0.
- FSM states: S_IDLE, S_CONV, S_RESP.
- S_IDLE, on a clock edge with any i_req high:
  - Winner = first set bit searching from pointer+1 modulo NREQ.
  - Capture i_argA slice of the winner into the operand register and the winner index into o_id.
  - Pointer <= winner.
  - Set o_gnt[winner] = 1 for exactly the next cycle.
  - Go to S_CONV.
- S_IDLE with no request: stay; o_gnt = 0.
- S_CONV:
  - Operand register drives the changecode instance.
  - At the next edge, register o_result and o_error, set o_valid = 1, clear o_gnt, go to S_RESP.
- S_RESP:
  - Hold o_valid, o_result, o_error and o_id stable while i_ready = 0.
  - On an edge with o_valid && i_ready: clear o_valid and go to S_IDLE.
  - Requests are not arbitrated in S_RESP.
- Latency:
  - Request sampled at edge T -> o_gnt high during cycle T..T+1.
  - o_valid high from edge T+1.
  - Minimum request-to-request spacing is 3 cycles (ready tied high).
- Conversion rules (changecode, identical semantics):
  - Operand >= 0: result = operand, error = 0.
  - Operand = -(2^(BITS-1)): result = operand, error = 1.
  - Otherwise: result = sign bit set, magnitude = -operand, error = 0.
- Requester handshake:
  - Requester keeps i_req and its operand stable until it sees its o_gnt bit, then drops i_req in the following cycle.
  - A requester that drops i_req before being granted is simply skipped; this is not an error.
  - A requester still holding i_req after its grant is treated as a new request and re-arbitrated behind the others.
- Simultaneous events: all requests arriving on the same edge are arbitrated in pointer order. No starvation; every requester is granted within NREQ transactions.
- Reset mid-operation: asynchronous clear to the reset values. Any in-flight operand or result is discarded without o_valid. After release, arbitration restarts from requester 0.

Optional Feature:
- Macro CHANGECODE_STATS_EN.
- When defined, two extra output ports are present:
  - o_cnt_done [15:0]: increments on every accepted result (o_valid && i_ready).
  - o_cnt_err [15:0]: increments on accepted results with o_error = 1.
  - Both saturate at 16'hFFFF and reset to 0 asynchronously.
- When undefined, the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- changecode_pkg holds:
  - typedef enum logic [1:0] state_t {S_IDLE, S_CONV, S_RESP}.
  - CNT_W = 16.
  - A next-index helper function for the round-robin search.
- Sub-module rr_arbiter (parameter NREQ, combinational):
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, winner index, any-valid flag.
- changecode_sched instantiates rr_arbiter and the existing changecode unit (BITS passed through).

Test Plan:
- BITS=4, NREQ=4; only requester 1 requests with operand 4'b1101 (-3), i_ready=1 -> o_gnt = 4'b0010 for one cycle; o_valid next cycle with o_result = 4'b1011, o_error = 0, o_id = 1.
- Requester 2 requests with operand 4'b1000 -> o_result = 4'b1000, o_error = 1, o_id = 2. With CHANGECODE_STATS_EN: o_cnt_err = 1, o_cnt_done = 1.
- Requester 0 requests with operand 4'b0101 -> o_result = 4'b0101, o_error = 0, o_id = 0.
- All four requesters request on the same edge, each re-asserting after its result is accepted -> grant order 0,1,2,3,0; each grant 3 cycles apart; o_id sequence matches.
- Backpressure: i_ready = 0 for 5 cycles during S_RESP -> o_valid, o_result and o_id stay stable; no o_gnt issued even though other requests are pending; on i_ready = 1, the result is accepted and the next grant follows.
- Drive i_rst_n low during S_CONV -> all outputs 0 immediately and no o_valid appears. After release with requesters 3 and 0 active, the first grant goes to requester 0.

Source files
------------

// File: rtl/changecode_pkg.sv
// -----------------------------------------------------------------------------
// changecode_pkg
// Shared types and helpers for the changecode scheduler:
//   state_t     - scheduler FSM encoding (S_IDLE, S_CONV, S_RESP)
//   CNT_W       - width of the optional statistics counters
//   rr_next_idx - round-robin successor of an index modulo n
// -----------------------------------------------------------------------------
package changecode_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  // Next index after cur, wrapping to 0 at n.
  function automatic int unsigned rr_next_idx(input int unsigned cur,
                                              input int unsigned n);
    return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/changecode.sv
// -----------------------------------------------------------------------------
// changecode
// Combinational two's complement -> sign-magnitude converter.
//   operand >= 0            : result = operand,              error = 0
//   operand == -(2^(BITS-1)): result = operand,              error = 1
//   otherwise               : result = {1, magnitude(-op)},  error = 0
// Ports:
//   i_op     [BITS-1:0] signed operand
//   o_result [BITS-1:0] sign-magnitude result
//   o_error             operand has no sign-magnitude representation
// -----------------------------------------------------------------------------
module changecode #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] i_op,
  output logic [BITS-1:0] o_result,
  output logic            o_error
);

  localparam logic [BITS-2:0] LSB_ONE = (BITS-1)'(1);

  // Magnitude of a negative operand; only the low BITS-1 bits are needed
  // because the most negative value is handled separately.
  logic [BITS-2:0] w_mag;
  assign w_mag = ~i_op[BITS-2:0] + LSB_ONE;

  always_comb begin
    o_result = i_op;
    o_error  = 1'b0;
    if (i_op[BITS-1]) begin
      if (i_op[BITS-2:0] == '0) begin
        o_error = 1'b1;
      end else begin
        o_result = {1'b1, w_mag};
      end
    end
  end

endmodule

// File: rtl/changecode_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at i_ptr+1 (mod NREQ)
// and picks the first asserted request.
// Ports:
//   i_req    [NREQ-1:0] request vector
//   i_ptr    [IDW-1:0]  index of the last winner
//   o_onehot [NREQ-1:0] one-hot winner (zero when nothing requests)
//   o_idx    [IDW-1:0]  winner index
//   o_any               at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter
  import changecode_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  always_comb begin
    int unsigned k;
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    k        = rr_next_idx(int'(i_ptr), NREQ);
    for (int i = 0; i < NREQ; i++) begin
      if (!o_any && i_req[k]) begin
        o_any       = 1'b1;
        o_idx       = IDW'(k);
        o_onehot[k] = 1'b1;
      end
      k = rr_next_idx(k, NREQ);
    end
  end

endmodule

// File: rtl/changecode_sched.sv
// -----------------------------------------------------------------------------
// changecode_sched
// Round-robin scheduler sharing one changecode unit between NREQ requesters.
// A request is granted (one-cycle o_gnt pulse), its operand captured and
// converted, and the registered result returned with the owner ID over a
// valid/ready handshake. One conversion in flight at a time.
// Optional feature: define CHANGECODE_STATS_EN to add o_cnt_done/o_cnt_err,
// saturating counters of accepted results and accepted error results.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_req    [NREQ-1:0]      level requests, held until granted
//   i_argA   [NREQ*BITS-1:0] packed operands, slice k belongs to requester k
//   o_gnt    [NREQ-1:0]      one-hot grant pulse
//   o_valid / i_ready        result handshake
//   o_result [BITS-1:0]      converted result
//   o_error                  operand was the most negative value
//   o_id     [IDW-1:0]       owner of the result
//   o_busy                   FSM not idle
// -----------------------------------------------------------------------------
module changecode_sched
  import changecode_pkg::*;
#(
  parameter  int BITS = 4,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*BITS-1:0] i_argA,
  output logic [NREQ-1:0]      o_gnt,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [BITS-1:0]      o_result,
  output logic                 o_error,
  output logic [IDW-1:0]       o_id,
  output logic                 o_busy
`ifdef CHANGECODE_STATS_EN
  ,
  output logic [CNT_W-1:0]     o_cnt_done,
  output logic [CNT_W-1:0]     o_cnt_err
`endif
);

  state_t          r_state;
  state_t          w_next_state;
  logic [IDW-1:0]  r_ptr;
  logic [BITS-1:0] r_op;
  logic [NREQ-1:0] r_gnt;
  logic            r_valid;
  logic [BITS-1:0] r_result;
  logic            r_error;
  logic [IDW-1:0]  r_id;

  logic [NREQ-1:0] w_win_onehot;
  logic [IDW-1:0]  w_win_idx;
  logic            w_any;
  logic [BITS-1:0] w_sel_op;
  logic [BITS-1:0] w_cc_result;
  logic            w_cc_error;
  logic            w_grant_en;
  logic            w_conv_done;
  logic            w_accept;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  assign w_sel_op = i_argA[int'(w_win_idx)*BITS +: BITS];

  changecode #(
    .BITS (BITS)
  ) u_cc (
    .i_op     (r_op),
    .o_result (w_cc_result),
    .o_error  (w_cc_error)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-state strobes. Requests are only looked at in S_IDLE,
  // so pending requesters wait out backpressure in S_RESP.
  always_comb begin
    w_next_state = r_state;
    w_grant_en   = 1'b0;
    w_conv_done  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_en   = 1'b1;
          w_next_state = S_CONV;
        end
      end
      S_CONV: begin
        w_conv_done  = 1'b1;
        w_next_state = S_RESP;
      end
      S_RESP: begin
        if (r_valid && i_ready) begin
          w_accept     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath. Pointer resets to NREQ-1 so requester 0 is searched first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr    <= IDW'(NREQ-1);
      r_op     <= '0;
      r_gnt    <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_error  <= 1'b0;
      r_id     <= '0;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // read in this block sees the pre-edge value, regardless of order.
      if (w_grant_en) begin
        r_op  <= w_sel_op;
        r_id  <= w_win_idx;
        r_ptr <= w_win_idx;
        r_gnt <= w_win_onehot;
      end
      if (w_conv_done) begin
        r_result <= w_cc_result;
        r_error  <= w_cc_error;
        r_valid  <= 1'b1;
        r_gnt    <= '0;
      end
      if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef CHANGECODE_STATS_EN
  logic [CNT_W-1:0] r_cnt_done;
  logic [CNT_W-1:0] r_cnt_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_done <= '0;
      r_cnt_err  <= '0;
    end else if (w_accept) begin
      if (r_cnt_done != '1) begin
        r_cnt_done <= r_cnt_done + CNT_W'(1);
      end
      if (r_error && (r_cnt_err != '1)) begin
        r_cnt_err <= r_cnt_err + CNT_W'(1);
      end
    end
  end

  assign o_cnt_done = r_cnt_done;
  assign o_cnt_err  = r_cnt_err;
`endif

  assign o_gnt    = r_gnt;
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_error  = r_error;
  assign o_id     = r_id;
  assign o_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_changecode_sched.sv
// -----------------------------------------------------------------------------
// tb_changecode_sched
// Directed bench for changecode_sched (BITS=4, NREQ=4). Inputs are driven and
// outputs sampled on the falling clock edge. Define CHANGECODE_STATS_EN to
// also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_changecode_sched;

  localparam int BITS = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 i_clk;
  logic                 i_rst_n;
  logic [NREQ-1:0]      i_req;
  logic [NREQ*BITS-1:0] i_argA;
  logic [NREQ-1:0]      o_gnt;
  logic                 o_valid;
  logic                 i_ready;
  logic [BITS-1:0]      o_result;
  logic                 o_error;
  logic [IDW-1:0]       o_id;
  logic                 o_busy;
`ifdef CHANGECODE_STATS_EN
  logic [15:0]          o_cnt_done;
  logic [15:0]          o_cnt_err;
`endif

  int n_total;
  int n_bad;

  changecode_sched #(
    .BITS (BITS),
    .NREQ (NREQ)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req),
    .i_argA   (i_argA),
    .o_gnt    (o_gnt),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_error  (o_error),
    .o_id     (o_id),
    .o_busy   (o_busy)
`ifdef CHANGECODE_STATS_EN
    ,
    .o_cnt_done (o_cnt_done),
    .o_cnt_err  (o_cnt_err)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic set_op(input int k, input logic [BITS-1:0] v);
    i_argA[k*BITS +: BITS] = v;
  endtask

  task automatic reset_dut();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req   = '0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  // One isolated transaction with ready tied high.
  task automatic do_single(input string tag, input int k,
                           input logic [BITS-1:0] op,
                           input logic [BITS-1:0] exp_res,
                           input logic exp_err);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    set_op(k, op);
    i_ready = 1'b1;
    i_req   = oh;
    tick();
    check({tag, "_gnt"},   32'(o_gnt), 32'(oh));
    check({tag, "_busy"},  32'(o_busy), 32'd1);
    check({tag, "_nval"},  32'(o_valid), 32'd0);
    i_req = '0;
    tick();
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_res"},   32'(o_result), 32'(exp_res));
    check({tag, "_err"},   32'(o_error), 32'(exp_err));
    check({tag, "_id"},    32'(o_id), 32'(k));
    check({tag, "_gnt0"},  32'(o_gnt), 32'd0);
    tick();
    check({tag, "_done"},  32'(o_valid), 32'd0);
    check({tag, "_idle"},  32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [BITS-1:0] exp_tab [NREQ];
    int              exp_order [5];
    logic [NREQ-1:0] req_m;
    logic [NREQ-1:0] reassert;
    int              ng;
    int              last_cyc;
    int              last_gnt;
    int              gidx;

    n_total = 0;
    n_bad   = 0;
    i_rst_n = 1'b0;
    i_req   = '0;
    i_argA  = '0;
    i_ready = 1'b1;
    repeat (2) @(negedge i_clk);

    // Reset state.
    check("rst_gnt",   32'(o_gnt), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_res",   32'(o_result), 32'd0);
    check("rst_err",   32'(o_error), 32'd0);
    check("rst_id",    32'(o_id), 32'd0);
    check("rst_busy",  32'(o_busy), 32'd0);
    i_rst_n = 1'b1;
    tick();
    check("idle_gnt", 32'(o_gnt), 32'd0);

    // -3 -> sign-magnitude 1011.
    do_single("t1", 1, 4'b1101, 4'b1011, 1'b0);
`ifdef CHANGECODE_STATS_EN
    check("t1_cnt_done", 32'(o_cnt_done), 32'd1);
    check("t1_cnt_err",  32'(o_cnt_err), 32'd0);
`endif

    // Most negative value flags an error.
    reset_dut();
    do_single("t2", 2, 4'b1000, 4'b1000, 1'b1);
`ifdef CHANGECODE_STATS_EN
    check("t2_cnt_done", 32'(o_cnt_done), 32'd1);
    check("t2_cnt_err",  32'(o_cnt_err), 32'd1);
`endif

    // Positive operand passes through.
    do_single("t3", 0, 4'b0101, 4'b0101, 1'b0);

    // All four request together; each re-asserts after its result is taken.
    reset_dut();
    set_op(0, 4'b0011); exp_tab[0] = 4'b0011;
    set_op(1, 4'b1111); exp_tab[1] = 4'b1001;
    set_op(2, 4'b0000); exp_tab[2] = 4'b0000;
    set_op(3, 4'b1010); exp_tab[3] = 4'b1110;
    exp_order = '{0, 1, 2, 3, 0};
    i_ready  = 1'b1;
    req_m    = 4'b1111;
    reassert = '0;
    i_req    = req_m;
    ng       = 0;
    last_cyc = 0;
    last_gnt = 0;
    for (int c = 1; c <= 40 && ng < 5; c++) begin
      tick();
      req_m    = req_m | reassert;
      reassert = '0;
      if (o_gnt != '0) begin
        gidx = -1;
        for (int j = 0; j < NREQ; j++) if (o_gnt[j]) gidx = j;
        check("rr_order", 32'(gidx), 32'(exp_order[ng]));
        if (ng > 0) check("rr_spacing", 32'(c - last_cyc), 32'd3);
        last_cyc = c;
        last_gnt = gidx;
        ng++;
        req_m = req_m & ~o_gnt;
      end
      if (o_valid) begin
        check("rr_id",  32'(o_id), 32'(last_gnt));
        check("rr_res", 32'(o_result), 32'(exp_tab[last_gnt]));
        reassert[last_gnt] = 1'b1;
      end
      i_req = req_m;
    end
    check("rr_count", 32'(ng), 32'd5);
    i_req = '0;
    tick();
    check("rr_last_valid", 32'(o_valid), 32'd1);
    check("rr_last_id",    32'(o_id), 32'd0);
    tick();
    check("rr_drain", 32'(o_busy), 32'd0);

    // Backpressure: requester 2 waits while requester 1's result is held.
    i_ready = 1'b0;
    i_req   = 4'b0110;
    tick();
    check("bp_gnt1", 32'(o_gnt), 32'b0010);
    i_req = 4'b0100;
    tick();
    check("bp_valid", 32'(o_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", 32'(o_valid), 32'd1);
      check("bp_hold_res",   32'(o_result), 32'b1001);
      check("bp_hold_id",    32'(o_id), 32'd1);
      check("bp_no_gnt",     32'(o_gnt), 32'd0);
    end
    i_ready = 1'b1;
    tick();
    check("bp_accepted", 32'(o_valid), 32'd0);
    check("bp_gap_gnt",  32'(o_gnt), 32'd0);
    tick();
    check("bp_gnt2", 32'(o_gnt), 32'b0100);
    i_req = '0;
    tick();
    check("bp_id2",  32'(o_id), 32'd2);
    check("bp_res2", 32'(o_result), 32'b0000);
    tick();

    // Reset in S_CONV discards the operation.
    i_req = 4'b0010;
    tick();
    check("rc_gnt", 32'(o_gnt), 32'b0010);
    i_req = '0;
    #1 i_rst_n = 1'b0;
    #1;
    check("rc_gnt0",  32'(o_gnt), 32'd0);
    check("rc_busy0", 32'(o_busy), 32'd0);
    check("rc_val0",  32'(o_valid), 32'd0);
    check("rc_id0",   32'(o_id), 32'd0);
    tick();
    tick();
    check("rc_noval", 32'(o_valid), 32'd0);
    i_req   = 4'b1001;
    i_rst_n = 1'b1;
    tick();
    check("rc_first_gnt", 32'(o_gnt), 32'b0001);
    i_req = 4'b1000;
    tick();
    check("rc_id_a",  32'(o_id), 32'd0);
    check("rc_res_a", 32'(o_result), 32'b0011);
    tick();
    tick();
    check("rc_second_gnt", 32'(o_gnt), 32'b1000);
    i_req = '0;
    tick();
    check("rc_id_b",  32'(o_id), 32'd3);
    check("rc_res_b", 32'(o_result), 32'b1110);
    tick();
    check("rc_idle", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
